// File: rtl/sdram_port_pkg.sv
// Shared types and constants for the cache-to-SDRAM fill port.
// Latency: n/a; backpressure: n/a.
package sdram_port_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        REPLAY,
        WR_ISSUE,
        WR_WAIT,
        HOLD
    } state_t;

    localparam int BURST_WORDS_DEFAULT = 4;
    localparam logic [1:0] DQM_NONE = 2'b11;

    // Byte-address bits covered by one line of 16-bit words.
    function automatic int line_shift(input int burst_words);
        return $clog2(burst_words) + 1;
    endfunction

    localparam int LINE_SHIFT = line_shift(BURST_WORDS_DEFAULT);

endpackage

// File: rtl/fill_line_buffer.sv
// One-line register file: single write port, registered read port.
// Latency: read data 1 cycle after raddr; backpressure: none.
module fill_line_buffer
    import sdram_port_pkg::*;
#(
    parameter int WORDS = BURST_WORDS_DEFAULT,
    parameter int IDX_W = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [15:0]      wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [15:0]      rdata
);

    logic [15:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sdram_fill_port.sv
// Gathers a cache line word-by-word from SDRAM and replays it as a gap-free burst; passes masked word writes.
// Latency: fill the cycle after the last sd_ack, wr_ack the cycle after sd_ack; backpressure: sd_req held until sd_ack, none on replay.
module sdram_fill_port
    import sdram_port_pkg::*;
#(
    parameter int BURST_WORDS = BURST_WORDS_DEFAULT,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cache_req,
    input  logic                  cache_rw,
    input  logic [ADDR_WIDTH-1:0] cache_addr,
    input  logic [15:0]           cache_wdata,
    input  logic                  cache_wru,
    input  logic                  cache_wrl,
    output logic                  fill,
    output logic [15:0]           fill_data,
    output logic                  wr_ack,
    output logic                  busy,
    output logic                  sd_req,
    output logic                  sd_we,
    output logic [ADDR_WIDTH-1:0] sd_addr,
    output logic [15:0]           sd_wdata,
    output logic [1:0]            sd_dqm,
    input  logic                  sd_ack,
    input  logic [15:0]           sd_rdata
);

    localparam int CW = $clog2(BURST_WORDS);
    localparam int LS = line_shift(BURST_WORDS);
    localparam logic [CW-1:0] LAST = CW'(BURST_WORDS - 1);

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_nxt;
    logic [ADDR_WIDTH-LS-1:0] line_hi;
    logic [1:0]           wr_mask;
    logic                 acked;
    logic                 buf_we;
    logic [CW-1:0]        buf_raddr;

    assign cnt_nxt = cnt + 1'b1;
    assign acked   = sd_req && sd_ack;
    assign busy    = (state != IDLE);
    assign buf_we  = (state == RD_WAIT) && acked;
    // Read one word ahead so the registered buffer output lines up with fill.
    assign buf_raddr = (state == REPLAY) ? cnt_nxt : '0;

    fill_line_buffer #(
        .WORDS (BURST_WORDS),
        .IDX_W (CW)
    ) u_line_buf (
        .clk   (clk),
        .reset (reset),
        .we    (buf_we),
        .waddr (cnt),
        .wdata (sd_rdata),
        .raddr (buf_raddr),
        .rdata (fill_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fill     <= 1'b0;
            wr_ack   <= 1'b0;
            sd_req   <= 1'b0;
            sd_we    <= 1'b0;
            sd_addr  <= '0;
            sd_wdata <= '0;
            sd_dqm   <= DQM_NONE;
            cnt      <= '0;
            line_hi  <= '0;
            wr_mask  <= DQM_NONE;
        end else begin
            fill   <= 1'b0;
            wr_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (cache_req) begin
                        if (cache_rw) begin
                            line_hi <= cache_addr[ADDR_WIDTH-1:LS];
                            cnt     <= '0;
                            state   <= RD_ISSUE;
                        end else begin
                            sd_addr  <= cache_addr & ~ADDR_WIDTH'(1);
                            sd_wdata <= cache_wdata;
                            wr_mask  <= {~cache_wru, ~cache_wrl};
                            state    <= WR_ISSUE;
                        end
                    end
                end
                RD_ISSUE: begin
                    sd_req  <= 1'b1;
                    sd_we   <= 1'b0;
                    sd_addr <= {line_hi, cnt, 1'b0};
                    state   <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (acked) begin
                        if (cnt == LAST) begin
                            cnt    <= '0;
                            sd_req <= 1'b0;
                            fill   <= 1'b1;
                            state  <= REPLAY;
                        end else begin
                            // Next word goes out immediately; sd_req never drops mid-line.
                            cnt     <= cnt_nxt;
                            sd_addr <= {line_hi, cnt_nxt, 1'b0};
                        end
                    end
                end
                REPLAY: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= HOLD;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                WR_ISSUE: begin
                    sd_req <= 1'b1;
                    sd_we  <= 1'b1;
                    sd_dqm <= wr_mask;
                    state  <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (acked) begin
                        sd_req <= 1'b0;
                        sd_we  <= 1'b0;
                        wr_ack <= 1'b1;
                        state  <= HOLD;
                    end
                end
                HOLD: begin
                    // The cache keeps cache_req high briefly; wait it out to avoid a retrigger.
                    if (!cache_req) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_fill_port.sv
// Scoreboard bench for sdram_fill_port: directed reads/writes against a small SDRAM controller model.
// Latency: n/a; backpressure: controller model acks after a programmable wait.
module tb_sdram_fill_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        cache_req;
    logic        cache_rw;
    logic [31:0] cache_addr;
    logic [15:0] cache_wdata;
    logic        cache_wru;
    logic        cache_wrl;
    logic        fill;
    logic [15:0] fill_data;
    logic        wr_ack;
    logic        busy;
    logic        sd_req;
    logic        sd_we;
    logic [31:0] sd_addr;
    logic [15:0] sd_wdata;
    logic [1:0]  sd_dqm;
    logic        sd_ack;
    logic [15:0] sd_rdata;

    sdram_fill_port #(.BURST_WORDS(4), .ADDR_WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .cache_req   (cache_req),
        .cache_rw    (cache_rw),
        .cache_addr  (cache_addr),
        .cache_wdata (cache_wdata),
        .cache_wru   (cache_wru),
        .cache_wrl   (cache_wrl),
        .fill        (fill),
        .fill_data   (fill_data),
        .wr_ack      (wr_ack),
        .busy        (busy),
        .sd_req      (sd_req),
        .sd_we       (sd_we),
        .sd_addr     (sd_addr),
        .sd_wdata    (sd_wdata),
        .sd_dqm      (sd_dqm),
        .sd_ack      (sd_ack),
        .sd_rdata    (sd_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [15:0] wdata;
        logic [1:0]  dqm;
    } sd_exp_t;

    sd_exp_t     exp_sd[$];
    logic [15:0] exp_fill[$];
    int          wrack_pushed = 0;
    int          wrack_seen   = 0;
    int          checks = 0;
    int          errors = 0;
    int          acks = 0;
    int          req_cycles = 0;
    int          fill_cnt = 0;
    int          ack_target = 0;
    int          lat = 0;
    logic [15:0] data_base = 16'h0;
    int          stray_cnt = 0;
    int          stray_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic bit cond_met(input int sel);
        case (sel)
            0:       return fill;
            1:       return wr_ack;
            2:       return !busy;
            default: return acks >= ack_target;
        endcase
    endfunction

    task automatic wait_for(input string name, input int sel, output int n);
        n = 0;
        while (!cond_met(sel) && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, 32'(cond_met(sel)), 32'd1);
    endtask

    task automatic push_rd(input logic [31:0] base, input logic [15:0] d0);
        for (int i = 0; i < 4; i++) begin
            exp_sd.push_back('{addr: base + 32'(2 * i), we: 1'b0, wdata: 16'h0, dqm: 2'b00});
            exp_fill.push_back(d0 + 16'(i));
        end
    endtask

    // SDRAM controller model: acks after lat idle cycles, data derived from the word index.
    initial begin
        int wait_cnt;
        sd_ack   = 1'b0;
        sd_rdata = 16'h0;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (stray_cnt != stray_done) begin
                sd_ack   = 1'b1;
                sd_rdata = 16'hDEAD;
                stray_done++;
            end else if (sd_req) begin
                if (wait_cnt >= lat) begin
                    sd_ack   = 1'b1;
                    sd_rdata = data_base + 16'(sd_addr[2:1]);
                    wait_cnt = 0;
                end else begin
                    sd_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                sd_ack   = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Monitor: compares every controller handshake, replay word and write ack against the queues.
    initial begin
        int rem;
        sd_exp_t e;
        rem = 0;
        forever begin
            @(negedge clk);
            #2;
            if (sd_req) req_cycles++;
            if (sd_req && sd_ack) begin
                acks++;
                if (exp_sd.size() == 0) begin
                    chk("sd_unexpected_req", 32'd1, 32'd0);
                end else begin
                    e = exp_sd.pop_front();
                    chk("sd_addr", sd_addr, e.addr);
                    chk("sd_we", 32'(sd_we), 32'(e.we));
                    if (e.we) begin
                        chk("sd_wdata", 32'(sd_wdata), 32'(e.wdata));
                        chk("sd_dqm", 32'(sd_dqm), 32'(e.dqm));
                    end
                end
            end
            if (fill) begin
                fill_cnt++;
                chk("fill_inside_burst", 32'(rem), 32'd0);
                rem = 4;
            end
            if (rem > 0) begin
                if (exp_fill.size() == 0) chk("fill_unexpected", 32'd1, 32'd0);
                else chk("fill_data", 32'(fill_data), 32'(exp_fill.pop_front()));
                rem--;
            end
            if (wr_ack) begin
                chk("wr_ack_expected", 32'(wrack_pushed > wrack_seen), 32'd1);
                wrack_seen++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int f0;
        int a0;
        reset       = 1'b1;
        cache_req   = 1'b0;
        cache_rw    = 1'b0;
        cache_addr  = 32'h0;
        cache_wdata = 16'h0;
        cache_wru   = 1'b0;
        cache_wrl   = 1'b0;
        step(3);
        reset = 1'b0;
        step(2);
        chk("rst_fill", 32'(fill), 32'd0);
        chk("rst_wr_ack", 32'(wr_ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sd_req", 32'(sd_req), 32'd0);
        chk("rst_sd_we", 32'(sd_we), 32'd0);
        chk("rst_sd_addr", sd_addr, 32'd0);
        chk("rst_sd_wdata", 32'(sd_wdata), 32'd0);
        chk("rst_fill_data", 32'(fill_data), 32'd0);
        chk("rst_sd_dqm", 32'(sd_dqm), 32'h3);

        // Line read, controller waits 2 cycles per word.
        lat = 2;
        data_base = 16'hA000;
        push_rd(32'h0001_2340, 16'hA000);
        cache_rw   = 1'b1;
        cache_addr = 32'h0001_2346;
        cache_req  = 1'b1;
        wait_for("rd1_fill_timeout", 0, n);
        cache_req = 1'b0;
        wait_for("rd1_idle_timeout", 2, n);

        // Zero-latency acks; request stays high 6 cycles after fill.
        lat = 0;
        data_base = 16'h1230;
        push_rd(32'h0000_4000, 16'h1230);
        req_cycles = 0;
        f0 = fill_cnt;
        cache_addr = 32'h0000_4007;
        cache_req  = 1'b1;
        wait_for("rd2_fill_timeout", 0, n);
        chk("rd2_latency", 32'(n), 32'd6);
        step(6);
        chk("rd2_one_fill", 32'(fill_cnt - f0), 32'd1);
        chk("rd2_req_cycles", 32'(req_cycles), 32'd4);
        chk("rd2_hold_busy", 32'(busy), 32'd1);
        cache_req = 1'b0;
        step(2);
        chk("rd2_idle", 32'(busy), 32'd0);

        // Write upper byte only; block holds until the request drops.
        lat = 1;
        exp_sd.push_back('{addr: 32'h100, we: 1'b1, wdata: 16'h55AA, dqm: 2'b01});
        wrack_pushed++;
        cache_rw    = 1'b0;
        cache_addr  = 32'h100;
        cache_wdata = 16'h55AA;
        cache_wru   = 1'b1;
        cache_wrl   = 1'b0;
        cache_req   = 1'b1;
        wait_for("wr1_ack_timeout", 1, n);
        step(3);
        chk("wr1_hold_busy", 32'(busy), 32'd1);
        chk("wr1_hold_no_req", 32'(sd_req), 32'd0);
        chk("wr1_we_cleared", 32'(sd_we), 32'd0);
        cache_req = 1'b0;
        step(2);
        chk("wr1_idle", 32'(busy), 32'd0);

        // Write with no byte enables: still issued, masks both bytes, odd address aligned.
        exp_sd.push_back('{addr: 32'h202, we: 1'b1, wdata: 16'h1234, dqm: 2'b11});
        wrack_pushed++;
        cache_addr  = 32'h203;
        cache_wdata = 16'h1234;
        cache_wru   = 1'b0;
        cache_wrl   = 1'b0;
        cache_req   = 1'b1;
        wait_for("wr2_ack_timeout", 1, n);
        cache_req = 1'b0;
        wait_for("wr2_idle_timeout", 2, n);

        // Reset after the second word of a fill, then a stray ack in IDLE.
        lat = 1;
        data_base = 16'hB000;
        exp_sd.push_back('{addr: 32'h800, we: 1'b0, wdata: 16'h0, dqm: 2'b00});
        exp_sd.push_back('{addr: 32'h802, we: 1'b0, wdata: 16'h0, dqm: 2'b00});
        a0 = acks;
        f0 = fill_cnt;
        ack_target = acks + 2;
        cache_rw   = 1'b1;
        cache_addr = 32'h800;
        cache_req  = 1'b1;
        wait_for("rst_mid_ack_timeout", 3, n);
        reset     = 1'b1;
        cache_req = 1'b0;
        step(1);
        chk("rst_mid_sd_req", 32'(sd_req), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        step(1);
        stray_cnt++;
        step(8);
        chk("rst_mid_acks", 32'(acks - a0), 32'd2);
        chk("rst_mid_no_fill", 32'(fill_cnt - f0), 32'd0);
        chk("stray_busy", 32'(busy), 32'd0);
        chk("stray_sd_req", 32'(sd_req), 32'd0);

        // Same line again: a fresh, complete fill with new data.
        lat = 0;
        data_base = 16'hC000;
        push_rd(32'h800, 16'hC000);
        cache_addr = 32'h806;
        cache_req  = 1'b1;
        wait_for("rd3_fill_timeout", 0, n);
        cache_req = 1'b0;
        wait_for("rd3_idle_timeout", 2, n);
        step(2);

        chk("sd_queue_empty", 32'(exp_sd.size()), 32'd0);
        chk("fill_queue_empty", 32'(exp_fill.size()), 32'd0);
        chk("wr_ack_count", 32'(wrack_seen), 32'(wrack_pushed));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_fill_port.md
Name: sdram_fill_port

Overview:
- Sits directly downstream of the two-way cache, between its SDRAM-side request port and the word-at-a-time SDRAM controller.
- For a cache line fill, issues one read per word of the line and collects the words in a line buffer. It then replays them to the cache as a gap-free burst, with `fill` asserted on the first word, which is the timing the cache's fill sequencer requires.
- Also carries single-word, byte-masked writes through to the controller and returns a one-cycle write acknowledge.

Parameters:
- BURST_WORDS, 4, words per cache line. Must be a power of 2 and at least 2.
- ADDR_WIDTH, 32, byte address width on both sides.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cache_req  in  1  request from cache. Held high until `fill` is seen (reads) or until `wr_ack` is seen (writes).
- cache_rw  in  1  1 = line read (fill), 0 = word write.
- cache_addr  in  ADDR_WIDTH  byte address. For reads, the low log2(BURST_WORDS)+1 bits are ignored.
- cache_wdata  in  16  write data.
- cache_wru  in  1  write upper byte.
- cache_wrl  in  1  write lower byte.
- fill  out  1  high for exactly one cycle, together with word 0 of the line.
- fill_data  out  16  replayed line word; valid on the `fill` cycle and the BURST_WORDS-1 cycles that follow.
- wr_ack  out  1  one-cycle pulse when the write has completed.
- busy  out  1  high in any state other than IDLE.
- sd_req  out  1  word request to controller. Held until `sd_ack`.
- sd_we  out  1  1 = write.
- sd_addr  out  ADDR_WIDTH  word byte-address (bit 0 = 0).
- sd_wdata  out  16  write data.
- sd_dqm  out  2  byte masks, active-high: {~wru, ~wrl}.
- sd_ack  in  1  one-cycle completion. Read data is valid in the same cycle.
- sd_rdata  in  16  read data.

Behaviour:
- Reset: state = IDLE; fill, wr_ack, busy, sd_req, sd_we = 0; sd_addr, sd_wdata, fill_data = 0; sd_dqm = 2'b11; word counter = 0.
- Reset takes priority over every state.
  - If reset arrives mid-operation, `sd_req` drops on the next cycle and the partial line is discarded.
  - A late `sd_ack` that arrives while in IDLE is ignored.
- States: IDLE, RD_ISSUE, RD_WAIT, REPLAY, WR_ISSUE, WR_WAIT, HOLD.
- IDLE:
  - cache_req & cache_rw → latch base = {cache_addr[AW-1:log2(BW)+1], zeros}; cnt = 0; go to RD_ISSUE.
  - cache_req & ~cache_rw → latch addr, data and masks; go to WR_ISSUE.
- RD_ISSUE: sd_req = 1, sd_we = 0, sd_addr = base + 2*cnt; go to RD_WAIT.
- RD_WAIT:
  - On `sd_ack`: buf[cnt] = sd_rdata.
  - If cnt = BW-1: cnt = 0, sd_req = 0, go to REPLAY.
  - Otherwise: cnt++, sd_addr updated in the same cycle, sd_req stays high (no idle gap), stay in RD_WAIT.
- REPLAY:
  - One word per cycle: fill_data = buf[cnt].
  - fill = 1 only when cnt = 0.
  - After cnt = BW-1, go to HOLD.
  - Exactly BW consecutive cycles; no stall input.
- WR_ISSUE: sd_req = 1, sd_we = 1, sd_dqm = {~wru, ~wrl}; go to WR_WAIT.
- WR_WAIT: on `sd_ack`: sd_req = 0, sd_we = 0, wr_ack = 1 for one cycle; go to HOLD.
- HOLD: wait for cache_req = 0, then go to IDLE. This prevents a held request from being retriggered.
- Edge cases:
  - If wru = wrl = 0, the write is still issued with sd_dqm = 11 and acknowledged normally.
  - `sd_ack` while sd_req = 0 is ignored in all states.
  - Address wrap past the top of the address space is not possible: base is line-aligned and cnt < BW.
- Latency:
  - fill is asserted the cycle after the last `sd_ack` of the line.
  - Minimum read, request to fill: 1 (IDLE) + 1 (RD_ISSUE) + BW ack cycles + 1.
  - wr_ack is asserted the cycle after `sd_ack`.

Decomposition:
- Shared package, sdram_port_pkg:
  - state enum;
  - BURST_WORDS default;
  - helper constant LINE_SHIFT = log2(BURST_WORDS)+1;
  - DQM_NONE = 2'b11.
- One sub-module, fill_line_buffer: BW×16 register file with write port (we, waddr, wdata) and registered read port (raddr → rdata).
  - The read address is presented one cycle ahead so that fill_data lines up with `fill`.

Test Plan:
- Reset then idle → all outputs at their reset values; busy = 0; sd_dqm = 11.
- Read of 0x0001_2346, controller acks after 2 cycles returning 0xA000..0xA003 → sd_addr sequence 0x12340, 0x12342, 0x12344, 0x12346; fill high for 1 cycle with fill_data = 0xA000; then 0xA001, 0xA002, 0xA003 on consecutive cycles.
- Back-to-back acks with zero latency (sd_ack held high for 4 cycles) → 4 words captured, sd_req stays high for exactly 4 acked cycles, replay as above.
- Write 0x55AA to 0x100, wru = 1, wrl = 0 → sd_we = 1, sd_dqm = 01, sd_wdata = 0x55AA; wr_ack pulses once; block stays in HOLD until cache_req drops.
- cache_req held high for 6 cycles after fill → exactly one fill burst, no second sd_req.
- Reset asserted after the 2nd ack of a fill, followed by a stray sd_ack → sd_req = 0 the next cycle, no fill, IDLE; the stray ack is ignored.
